// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the iterative divider.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package div_pkg;

  // Default operand/result width of the divider datapath.
  localparam int DIV_WIDTH = 32;

  // Controller states; DZERO is only entered when the fast divide-by-zero path is built in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    DONE  = 2'd2,
    DZERO = 2'd3
  } divState_t;

  // Magnitude of an operand: two's complement absolute value when signed, raw value otherwise.
  // The most negative value maps onto itself, which the unsigned core reads as 2^(W-1).
  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] value,
                                                   input logic                 isSigned);
    return (isSigned && value[DIV_WIDTH-1]) ? -value : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring division iteration on {rem, quo}.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the parent register loop sequences the iterations.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remNext,
  output logic [WIDTH-1:0] quoNext
);

  logic [WIDTH:0] minuend;
  logic           noBorrow;

  // Shift the next dividend bit into the partial remainder, trial-subtract, restore on borrow.
  // The partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value exactly;
  // with a zero divisor nothing is subtracted and the dividend simply shifts into rem.
  always_comb begin
    minuend  = {rem, quo[WIDTH-1]};
    noBorrow = (minuend >= {1'b0, divisor});
    remNext  = noBorrow ? WIDTH'(minuend - {1'b0, divisor}) : minuend[WIDTH-1:0];
    quoNext  = {quo[WIDTH-2:0], noBorrow};
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative DIV/DIVU responder; quotient -> lo_o, remainder -> hi_o. Optional macro: DIV_ZERO_FAST_EN.
// Latency: ready_o WIDTH+1 cycles after the accepted start (2 cycles for b==0 with DIV_ZERO_FAST_EN).
// Backpressure: busy_o (combinational in the issue cycle) stalls the issuer; start_i is ignored while busy.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  divState_t        state;
  divState_t        stateNext;
  logic             acceptStart;
  logic             lastStep;
  logic             zeroStep;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] remQ;
  logic [WIDTH-1:0] quoQ;
  logic [WIDTH-1:0] divisorQ;
  logic             signQ;
  logic             signR;
  logic [WIDTH-1:0] hiQ;
  logic [WIDTH-1:0] loQ;

  logic [WIDTH-1:0] remNext;
  logic [WIDTH-1:0] quoNext;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic             signA;
  logic             signB;

  // Conditional two's complement negate used for the final sign correction.
  function automatic logic [WIDTH-1:0] negIf(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Operand magnitudes and signs as they would be latched on an accepted start.
  always_comb begin
    magA  = abs_val(a_i, signed_i);
    magB  = abs_val(b_i, signed_i);
    signA = signed_i & a_i[WIDTH-1];
    signB = signed_i & b_i[WIDTH-1];
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem    (remQ),
    .quo    (quoQ),
    .divisor(divisorQ),
    .remNext(remNext),
    .quoNext(quoNext)
  );

  // State register; reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and handshake outputs; cancel wins over start and aborts without a ready pulse.
  always_comb begin
    stateNext   = state;
    acceptStart = 1'b0;
    lastStep    = 1'b0;
    zeroStep    = 1'b0;
    busy_o      = 1'b0;
    ready_o     = 1'b0;
    case (state)
      IDLE, DONE: begin
        ready_o = (state == DONE);
        if (start_i && !cancel_i) begin
          acceptStart = 1'b1;
          busy_o      = 1'b1;
`ifdef DIV_ZERO_FAST_EN
          stateNext   = (b_i == '0) ? DZERO : CALC;
`else
          stateNext   = CALC;
`endif
        end else begin
          stateNext = IDLE;
        end
      end
      CALC: begin
        busy_o = 1'b1;
        if (cancel_i) begin
          stateNext = IDLE;
        end else if (cnt == CNT_W'(WIDTH - 1)) begin
          lastStep  = 1'b1;
          stateNext = DONE;
        end
      end
`ifdef DIV_ZERO_FAST_EN
      DZERO: begin
        busy_o = 1'b1;
        if (cancel_i) begin
          stateNext = IDLE;
        end else begin
          zeroStep  = 1'b1;
          stateNext = DONE;
        end
      end
`endif
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Datapath: latch operands on accept, iterate in CALC, register the sign-corrected result on completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      remQ     <= '0;
      quoQ     <= '0;
      divisorQ <= '0;
      signQ    <= 1'b0;
      signR    <= 1'b0;
      hiQ      <= '0;
      loQ      <= '0;
    end else begin
      if (acceptStart) begin
        cnt      <= '0;
        remQ     <= '0;
        quoQ     <= magA;
        divisorQ <= magB;
        signQ    <= signA ^ signB;
        signR    <= signA;
      end else if (state == CALC) begin
        cnt      <= cnt + CNT_W'(1);
        remQ     <= remNext;
        quoQ     <= quoNext;
      end

      if (lastStep) begin
        hiQ <= negIf(remNext, signR);
        loQ <= negIf(quoNext, signQ);
      end else if (zeroStep) begin
        // Divide by zero: magnitude quotient is all ones and remainder is |a| (still held in quoQ).
        hiQ <= negIf(quoQ, signR);
        loQ <= negIf('1, signQ);
      end
    end
  end

  assign hi_o = hiQ;
  assign lo_o = loQ;

endmodule
